// File: rtl/m_ext_sequencer.sv
// m_ext_sequencer: control FSM for the EX-stage M-extension datapath.
// Sequences multi-cycle MUL/DIV operations (separate step counts), issues the
// operand-load and per-iteration step strobes, and holds done until ack.
// A flush aborts any in-flight or completed-but-unacknowledged operation.
//
// Build option: define M_EXT_DIV_EARLY_OUT_EN to let a divide by zero skip
// the iteration phase entirely (LOAD goes straight to DONE). Without it,
// div_zero is ignored and divides always take DIV_CYCLES steps.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no op in flight; waiting for start
// LOAD  | datapath latches operands; iteration counter cleared
// RUN   | one datapath iteration per cycle, iter = counter
// DONE  | result valid; held until ack (ack+start chains the next op)

module m_ext_sequencer #(
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 33,
  parameter int CNT_W      = $clog2(((MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES) + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_div,
  input  logic             div_zero,
  input  logic             flush,
  input  logic             ack,
  output logic             busy,
  output logic             load,
  output logic             step,
  output logic             done,
  output logic             op_div,
  output logic [CNT_W-1:0] iter
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV_CYCLES - 1);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             op_div_nxt;
  logic [CNT_W-1:0] last_idx;
  logic             at_last;
  logic             early_out;

  // The last iteration index depends on the op class latched at start.
  assign last_idx = op_div ? DIV_LAST : MUL_LAST;
  assign at_last  = (cnt == last_idx);

`ifdef M_EXT_DIV_EARLY_OUT_EN
  assign early_out = op_div & div_zero;
`else
  // div_zero stays on the port list so both builds share one interface.
  logic div_zero_unused;
  assign div_zero_unused = div_zero;
  assign early_out       = 1'b0;
`endif

  // Next-state, counter/op latch updates and Moore output decode.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    op_div_nxt = op_div;
    busy       = 1'b0;
    load       = 1'b0;
    step       = 1'b0;
    done       = 1'b0;
    iter       = '0;

    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt  = S_LOAD;
          op_div_nxt = is_div;
        end
      end
      S_LOAD: begin
        busy      = 1'b1;
        load      = 1'b1;
        cnt_nxt   = '0;
        state_nxt = early_out ? S_DONE : S_RUN;
      end
      S_RUN: begin
        busy = 1'b1;
        step = 1'b1;
        iter = cnt;
        if (at_last) begin
          state_nxt = S_DONE;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      S_DONE: begin
        busy = 1'b1;
        done = 1'b1;
        if (ack) begin
          if (start) begin
            state_nxt  = S_LOAD;
            op_div_nxt = is_div;
          end else begin
            state_nxt = S_IDLE;
          end
        end
      end
      default: begin
        state_nxt = S_IDLE;
        cnt_nxt   = '0;
      end
    endcase

    // Flush overrides everything, including a same-cycle start or ack.
    if (flush) begin
      state_nxt  = S_IDLE;
      cnt_nxt    = '0;
      op_div_nxt = op_div;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Iteration counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_nxt;
    end
  end

  // Op class of the current operation, captured when a start is accepted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_div <= 1'b0;
    end else begin
      op_div <= op_div_nxt;
    end
  end

endmodule
